window_sched: RTL and testbench
===============================

// Module: window_sched
// PURPOSE
//  Sequencer for the 3x3 convolution datapath: accepts a raster pixel stream and advances line buffers/window regs.
//  Issues a per-window calc strobe into the stage6 adder9x pipeline and tracks in-flight windows with a valid pipe.
//  Applies backpressure from the result consumer to the pixel source; produces (IMG_W-2)*(IMG_H-2) results per frame.
// PARAMETERS
//  IMG_W     640  pixels per row (>=3)
//  IMG_H     480  rows per frame (>=3)
//  PIPE_LAT  4    cycles from calc_valid to result at adder9x output (>=1); must match the datapath
//  CW        10   column counter width, ceil(log2(IMG_W))
//  RW        9    row counter width, ceil(log2(IMG_H))
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst        in   1   asynchronous, active-low reset
//  start      in   1   begin frame; sampled only in IDLE
//  pix_valid  in   1   upstream pixel valid
//  pix_ready  out  1   upstream pixel ready; transfer = pix_valid & pix_ready
//  win_en     out  1   = transfer; shift line buffers / window regs this cycle
//  pipe_en    out  1   clock enable for every datapath pipeline register (stage1..stage6)
//  calc_valid out  1   window in window regs is complete; enters the datapath this cycle
//  res_valid  out  1   datapath output (a/b) holds a valid result
//  res_ready  in   1   downstream accepts result
//  col        out  CW  column of the pixel being accepted
//  row        out  RW  row of the pixel being accepted
//  busy       out  1   state != IDLE
//  done       out  1   one-cycle pulse: last result of the frame handed off
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; col,row,vpipe=0; pix_ready,win_en,calc_valid,res_valid,busy,done=0; pipe_en=1.
//  pipe_en = ~res_valid | res_ready (the whole pipe freezes while the tail result is unaccepted).
//  vpipe[PIPE_LAT-1:0]: when pipe_en, vpipe <= {vpipe[PIPE_LAT-2:0], calc_valid}; otherwise hold. res_valid = vpipe[PIPE_LAT-1].
//  FSM:
//   IDLE : pix_ready=0; start -> RUN with col=row=0. start in any other state is ignored.
//   RUN  : pix_ready = pipe_en. Each transfer: col++ ; at col==IMG_W-1 col->0, row++.
//          calc_valid = transfer & row>=2 & col>=2 (border windows dropped; no padding).
//          transfer at (row=IMG_H-1, col=IMG_W-1) -> DRAIN; row,col -> 0.
//   DRAIN: pix_ready=0, calc_valid=0; when vpipe==0 -> IDLE with done=1 for one cycle.
//          Entry with vpipe already empty is impossible (last transfer issues calc_valid).
//  Latency: calc_valid at cycle t appears as res_valid at t+PIPE_LAT when pipe_en stays 1; each stalled cycle adds 1.
//  Simultaneous: result handoff and new calc in same cycle allowed (throughput 1/clk). pix_valid=0 creates bubbles; vpipe shifts them.
//  Reset mid-frame: frame abandoned, in-flight results discarded, no done; next frame starts on start.
//  col/row outputs hold last value in DRAIN/IDLE (0 after frame end).
// CONFIGURATION
//  WINDOW_SCHED_STATS_EN defined: extra outputs res_cnt[31:0] (results handed off this frame) and stall_cnt[31:0]
//   (cycles with res_valid & ~res_ready); both cleared on start in IDLE and on reset, saturate at 2^32-1.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package conv_pkg: sched_state_t enum {IDLE,RUN,DRAIN}; ADDER9X_LAT constant used as PIPE_LAT default by the top level.
//  Sub-module valid_pipe #(DEPTH): enabled valid shift register with async active-low clear; exposes tail and any-valid.
//  Counters, FSM and stats live in window_sched.
// TESTING (IMG_W=5, IMG_H=4, PIPE_LAT=3, res_ready=1 unless noted)
//  1 start, pix_valid=1 for 20 cycles -> exactly 6 calc_valid (row2/3 x col2..4), 6 res_valid each 3 cycles later, done 1 cycle after last result.
//  2 res_ready=0 for 5 cycles while res_valid=1 -> pix_ready=0, pipe_en=0, vpipe frozen; no result lost or duplicated, 6 total.
//  3 pix_valid toggled 1/0 -> col/row advance only on transfers; 6 results; bubbles visible in vpipe.
//  4 rst=0 asserted at row=2,col=3 -> all outputs to reset values same cycle; new start yields clean 6-result frame.
//  5 start pulsed during RUN and DRAIN -> ignored; start held high through done -> second frame begins the cycle after IDLE.
//  6 WINDOW_SCHED_STATS_EN with scenario 2 -> res_cnt=6, stall_cnt=5 at done.

Source files
------------

// File: rtl/window_sched_pkg.sv
// Shared types and constants for the 3x3 convolution window sequencer.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    // Latency of the adder9x datapath from calc strobe to result.
    localparam int ADDER9X_LAT = 4;

endpackage

// File: rtl/window_sched_if.sv
// Pixel-in / result-out handshake bundle plus the datapath control strobes.
interface window_sched_if #(
    parameter int CW = 10,
    parameter int RW = 9
);
    logic          pix_valid;
    logic          pix_ready;
    logic          win_en;
    logic          pipe_en;
    logic          calc_valid;
    logic          res_valid;
    logic          res_ready;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // Scheduler side.
    modport slave (
        input  pix_valid, res_ready,
        output pix_ready, win_en, pipe_en, calc_valid, res_valid, col, row
    );

    // Pixel source / result consumer side.
    modport master (
        output pix_valid, res_ready,
        input  pix_ready, win_en, pipe_en, calc_valid, res_valid, col, row
    );
endinterface

// File: rtl/window_sched_valid_pipe.sv
// Enabled valid shift register tracking windows in flight through the datapath.
module valid_pipe #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic in_vld,
    output logic tail,
    output logic any
);
    logic [DEPTH-1:0] vpipe_q, vpipe_d, shifted;

    if (DEPTH == 1) begin : g_d1
        assign shifted = in_vld;
    end else begin : g_dn
        assign shifted = {vpipe_q[DEPTH-2:0], in_vld};
    end

    // Shift only when the datapath advances; hold otherwise.
    always_comb begin
        vpipe_d = vpipe_q;
        if (en) vpipe_d = shifted;
    end

    // Valid pipe register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vpipe_q <= '0;
        else        vpipe_q <= vpipe_d;
    end

    assign tail = vpipe_q[DEPTH-1];
    assign any  = |vpipe_q;
endmodule

// File: rtl/window_sched.sv
// Raster scan sequencer for the 3x3 convolution datapath: accepts pixels,
// strobes complete windows into the adder pipe and drains it at frame end.
// Optional WINDOW_SCHED_STATS_EN adds res_cnt / stall_cnt frame statistics.
module window_sched
    import conv_pkg::*;
#(
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int PIPE_LAT = ADDER9X_LAT,
    parameter int CW       = 10,
    parameter int RW       = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         busy,
    output logic         done,
`ifdef WINDOW_SCHED_STATS_EN
    output logic [31:0]  res_cnt,
    output logic [31:0]  stall_cnt,
`endif
    window_sched_if.slave sif
);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    sched_state_t  state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          pipe_en, pix_ready, transfer, calc_valid, res_valid, any_valid;

    // A held tail result freezes the whole datapath and the pixel source.
    assign pipe_en    = ~res_valid | sif.res_ready;
    assign pix_ready  = (state_q == RUN) & pipe_en;
    assign transfer   = sif.pix_valid & pix_ready;
    // Border windows are dropped: only rows/cols >= 2 hold a full 3x3 window.
    assign calc_valid = transfer & (row_q >= RW'(2)) & (col_q >= CW'(2));

    valid_pipe #(.DEPTH(PIPE_LAT)) u_vpipe (
        .clk    (clk),
        .rst_n  (rst),
        .en     (pipe_en),
        .in_vld (calc_valid),
        .tail   (res_valid),
        .any    (any_valid)
    );

    // Next-state: raster counters advance on transfers, drain waits for empty pipe.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            RUN: begin
                if (transfer) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            state_d = DRAIN;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!any_valid) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and raster counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    assign busy           = (state_q != IDLE);
    assign sif.pix_ready  = pix_ready;
    assign sif.win_en     = transfer;
    assign sif.pipe_en    = pipe_en;
    assign sif.calc_valid = calc_valid;
    assign sif.res_valid  = res_valid;
    assign sif.col        = col_q;
    assign sif.row        = row_q;

`ifdef WINDOW_SCHED_STATS_EN
    logic [31:0] res_cnt_q, res_cnt_d, stall_cnt_q, stall_cnt_d;

    // Saturating per-frame handoff and stall counters, cleared when a frame starts.
    always_comb begin
        res_cnt_d   = res_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (state_q == IDLE && start) begin
            res_cnt_d   = '0;
            stall_cnt_d = '0;
        end else begin
            if (res_valid && sif.res_ready && res_cnt_q != '1)
                res_cnt_d = res_cnt_q + 32'd1;
            if (res_valid && !sif.res_ready && stall_cnt_q != '1)
                stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            res_cnt_q   <= res_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign res_cnt   = res_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_window_sched.sv
// Scoreboard bench for window_sched on a 5x4 image with a 3-deep pipe.
module tb_window_sched;
    localparam int W = 5, H = 4, LAT = 3, CW = 3, RW = 2;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, busy, done;
`ifdef WINDOW_SCHED_STATS_EN
    logic [31:0] res_cnt, stall_cnt;
`endif

    window_sched_if #(.CW(CW), .RW(RW)) sif ();

    window_sched #(.IMG_W(W), .IMG_H(H), .PIPE_LAT(LAT), .CW(CW), .RW(RW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
`ifdef WINDOW_SCHED_STATS_EN
        .res_cnt   (res_cnt),
        .stall_cnt (stall_cnt),
`endif
        .sif       (sif)
    );

    always #5 clk = ~clk;

    int vec = 0, err = 0;
    int cyc = 0, stalls = 0, done_cnt = 0, cur_mode = 0;
    logic [CW+RW-1:0] exp_win[$];
    int tq[$], sq[$];

    task automatic chk(string nm, int act, int exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Six interior windows of a 5x4 frame, in raster order.
    task automatic push_frame();
        logic [RW-1:0] r;
        logic [CW-1:0] c;
        for (int ri = 2; ri < H; ri++)
            for (int ci = 2; ci < W; ci++) begin
                r = RW'(ri);
                c = CW'(ci);
                exp_win.push_back({r, c});
            end
    endtask

    task automatic chk_reset_outs(string tag);
        chk({tag, "_pix_ready"}, int'(sif.pix_ready), 0);
        chk({tag, "_win_en"},    int'(sif.win_en), 0);
        chk({tag, "_calc"},      int'(sif.calc_valid), 0);
        chk({tag, "_res_valid"}, int'(sif.res_valid), 0);
        chk({tag, "_pipe_en"},   int'(sif.pipe_en), 1);
        chk({tag, "_busy"},      int'(busy), 0);
        chk({tag, "_done"},      int'(done), 0);
        chk({tag, "_col"},       int'(sif.col), 0);
        chk({tag, "_row"},       int'(sif.row), 0);
    endtask

    // Monitor: checks window positions, result latency, handshakes and frame ends.
    int   frame_res = 0, frame_calc = 0, last_hand = 0;
    logic held = 1'b0, prev_done = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            held = 1'b0; prev_done = 1'b0; frame_res = 0; frame_calc = 0;
            tq.delete(); sq.delete();
        end else begin
            if (sif.res_valid && !held) begin
                if (tq.size() == 0) chk("res_extra", 1, 0);
                else begin
                    int t, s;
                    t = tq.pop_front();
                    s = sq.pop_front();
                    chk("res_latency", cyc, t + LAT + (stalls - s));
                end
            end
            if (sif.calc_valid) begin
                frame_calc++;
                tq.push_back(cyc);
                sq.push_back(stalls);
                if (exp_win.size() == 0) chk("calc_extra", 1, 0);
                else chk("calc_pos", int'({sif.row, sif.col}), int'(exp_win.pop_front()));
            end
            chk("pipe_en", int'(sif.pipe_en), int'(!sif.res_valid || sif.res_ready));
            if (sif.res_valid && !sif.res_ready) begin
                stalls++;
                held = 1'b1;
                chk("stall_pix_ready", int'(sif.pix_ready), 0);
            end else held = 1'b0;
            if (sif.res_valid && sif.res_ready) begin
                frame_res++;
                last_hand = cyc;
            end
            if (done) begin
                chk("done_results", frame_res, 6);
                chk("done_calcs", frame_calc, 6);
                chk("done_timing", cyc, last_hand + 1);
`ifdef WINDOW_SCHED_STATS_EN
                chk("stat_res_cnt", int'(res_cnt), 6);
                chk("stat_stall_cnt", int'(stall_cnt), (cur_mode == 1) ? 5 : 0);
`endif
                done_cnt++;
                frame_res = 0;
                frame_calc = 0;
            end
            if (done && prev_done) chk("done_pulse_width", 2, 1);
            prev_done = done;
        end
    end

    // mode 0 plain, 1 consumer stall, 2 pix_valid toggling, 3 start pulses in RUN/DRAIN
    task automatic run_frame(int mode);
        int n, d0, stall_left;
        cur_mode = mode;
        push_frame();
        d0 = done_cnt;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        n = 0;
        stall_left = (mode == 1) ? 5 : 0;
        while (done_cnt == d0 && n < 200) begin
            sif.pix_valid = (mode == 2) ? n[0] : 1'b1;
            sif.res_ready = 1'b1;
            if (mode == 1 && stall_left > 0 && sif.res_valid) begin
                sif.res_ready = 1'b0;
                stall_left--;
            end
            start = (mode == 3 && (n == 5 || n == 21));
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        sif.res_ready = 1'b1;
        if (n >= 200) chk("frame_timeout", n, 0);
    endtask

    initial begin
        int n, d0;
        sif.pix_valid = 1'b0;
        sif.res_ready = 1'b1;
        #12;
        chk_reset_outs("por");
        @(posedge clk); #1; rst = 1'b1;
        #1 chk_reset_outs("idle");

        run_frame(0);
        run_frame(1);
        run_frame(2);
        run_frame(3);

        // start held through done: the next frame begins right after IDLE.
        cur_mode = 4;
        push_frame();
        push_frame();
        d0 = done_cnt;
        sif.pix_valid = 1'b1;
        start = 1'b1;
        n = 0;
        while (done_cnt == d0 && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) chk("held_timeout1", n, 0);
        #1 chk("held_idle_busy", int'(busy), 0);
        @(posedge clk); #2;
        chk("held_restart_busy", int'(busy), 1);
        chk("held_restart_ready", int'(sif.pix_ready), 1);
        start = 1'b0;
        n = 0;
        while (done_cnt == d0 + 1 && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) chk("held_timeout2", n, 0);

        // Reset mid-frame at row 2, col 3.
        cur_mode = 0;
        push_frame();
        d0 = done_cnt;
        @(posedge clk); #1; start = 1'b1; sif.pix_valid = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        n = 0;
        while (n < 200) begin
            @(posedge clk); #2;
            if (sif.row == RW'(2) && sif.col == CW'(3)) break;
            n++;
        end
        if (n >= 200) chk("mid_reset_timeout", n, 0);
        rst = 1'b0;
        exp_win.delete();
        #1 chk_reset_outs("mid_reset");
        @(posedge clk); @(posedge clk); #1; rst = 1'b1;
        chk("mid_reset_no_done", done_cnt, d0);
        run_frame(0);
        chk("total_frames", done_cnt, 7);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
